// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//
// Shared types and helpers for the data-memory load/store unit.
//   size_e  : access size encoding as it arrives on req_size
//   state_e : LSU control FSM states
//   misaligned()  : alignment rule for a given size and byte offset
//   needs_ram_q() : true for accesses that must wait for the RAM read data
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    // Halves must sit on an even byte, words on a multiple of four.
    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Everything except an aligned word store needs the old/loaded word from
    // the RAM, which only appears on ram_q one cycle after the address edge.
    function automatic logic needs_ram_q(input logic we, input size_e sz);
        return !(we && (sz == SZ_W));
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// ----------------------------------------------------------------------------
// byte_lane_align
//
// Purely combinational lane steering between a 32-bit RAM word and the
// right-justified data seen by the core.
//
// Ports
//   word_i     in  32  word read from the RAM
//   offset_i   in  2   byte offset of the access within the word
//   size_i     in  2   access size (size_e)
//   unsigned_i in  1   zero-extend loads when 1, sign-extend when 0
//   wdata_i    in  16  low half of the store data (only [7:0] used for bytes)
//   load_o     out 32  extracted and extended load value
//   merge_o    out 32  word_i with the addressed lane replaced by wdata_i
// ----------------------------------------------------------------------------
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [4:0]  bit_base;

    // Byte lane N starts at bit 8*N; half lanes are selected by offset[1] only.
    assign bit_base  = {offset_i, 3'b000};
    assign byte_lane = word_i[bit_base +: 8];
    assign half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_o  = word_i;
        merge_o = word_i;
        case (size_i)
            SZ_B: begin
                load_o                  = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
                merge_o[bit_base +: 8]  = wdata_i[7:0];
            end
            SZ_H: begin
                load_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
                if (offset_i[1]) begin
                    merge_o[31:16] = wdata_i;
                end else begin
                    merge_o[15:0]  = wdata_i;
                end
            end
            default: begin
                load_o  = word_i;
                merge_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// ----------------------------------------------------------------------------
// data_mem_lsu
//
// Load/store unit in front of a single-port, synchronous-read data RAM with no
// byte enables. Word stores are written in the accept cycle. Loads and
// sub-word stores read the addressed word first and finish one cycle later in
// RD_WAIT; sub-word stores write back the merged word there
// (read-modify-write). Misaligned, illegal-size and out-of-range requests get
// an error response and never touch the RAM.
//
// Ports
//   clock, reset     single clock; synchronous active-high reset
//   req_valid/ready  request handshake; ready only in IDLE and not in reset
//   req_we           1 = store, 0 = load
//   req_size         00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned     load zero-extends when 1
//   req_addr         byte address
//   req_wdata        right-justified store data
//   rsp_valid        one-cycle completion pulse
//   rsp_rdata        extended load data, 0 for stores and errors
//   rsp_error        error flag qualified by rsp_valid
//   ram_address/data/wren  RAM port drive
//   ram_q            RAM read data, valid the cycle after the address edge
// ----------------------------------------------------------------------------
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_error,
    output logic [DEPTH-1:0] ram_address,
    output logic [WIDTH-1:0] ram_data,
    output logic             ram_wren,
    input  logic [WIDTH-1:0] ram_q
);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_error_q, rsp_error_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    // Request fields held across RD_WAIT
    logic               we_q;
    size_e              size_q;
    logic               uns_q;
    logic [1:0]         off_q;
    logic [DEPTH-1:0]   waddr_q;
    logic [15:0]        wdata_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    size_e              req_sz;
    logic               out_of_range;
    logic               req_err;
    logic               accept;
    logic               capture;

    logic [31:0]        load_ext;
    logic [31:0]        store_merge;

    assign req_sz       = size_e'(req_size);
    assign out_of_range = (req_addr[31:DEPTH+2] != '0);
    assign req_err      = (req_sz == SZ_ILL) ||
                          misaligned(req_sz, req_addr[1:0]) ||
                          out_of_range;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    byte_lane_align u_align (
        .word_i     (ram_q),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_ext),
        .merge_o    (store_merge)
    );

    // ------------------------------------------------------------------
    // Next state, RAM drive and response
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        capture     = 1'b0;
        // Idle default: follow the live address so the read is harmless.
        ram_address = req_addr[DEPTH+1:2];
        ram_data    = req_wdata;
        ram_wren    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else if (!needs_ram_q(req_we, req_sz)) begin
                        ram_wren    = 1'b1;
                        rsp_valid_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // ram_q now holds the word addressed at accept.
                ram_address = waddr_q;
                ram_data    = store_merge;
                ram_wren    = we_q;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = we_q ? '0 : load_ext;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pending read-modify-write must never reach the RAM during reset.
        if (reset) begin
            ram_wren = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request fields are only meaningful in RD_WAIT, so they carry no reset.
    always_ff @(posedge clock) begin
        if (capture) begin
            we_q    <= req_we;
            size_q  <= req_sz;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            waddr_q <= req_addr[DEPTH+1:2];
            wdata_q <= req_wdata[15:0];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// ----------------------------------------------------------------------------
// tb_data_mem_lsu
//
// Drives data_mem_lsu against a behavioural synchronous-read RAM and checks
// every response and RAM write against a request-level reference memory.
// ----------------------------------------------------------------------------
module tb_data_mem_lsu;

    localparam int DEPTH = 8;
    localparam int NW    = 1 << DEPTH;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [DEPTH-1:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    always #5 clock = ~clock;

    data_mem_lsu #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q)
    );

    // Environment RAM: single port, registered read, contents preloaded once.
    logic [31:0] ram [NW];
    logic        load_ram = 1'b1;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    always @(posedge clock) begin
        if (load_ram) begin
            for (int i = 0; i < NW; i++) ram[i] <= init_word(i);
        end else if (ram_wren) begin
            ram[ram_address] <= ram_data;
        end
        ram_q <= ram[ram_address];
    end

    // Reference model state
    logic [31:0] ref_mem [NW];
    int n_vec  = 0;
    int n_err  = 0;
    int n_req  = 0;
    int n_pulse = 0;

    always @(negedge clock) begin
        if (rsp_valid) n_pulse++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(input bit [1:0] sz, input bit [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
               (sz == 2'd2 && (a % 4) != 0) || (a >= NW * 4);
    endfunction

    function automatic logic [31:0] ref_load(input bit [1:0] sz, input bit uns, input bit [31:0] a);
        logic [31:0] w, v;
        int sh;
        w  = ref_mem[a / 4];
        sh = 8 * (a % 4);
        if (sz == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
        logic [31:0] w, mask;
        int sh;
        w  = ref_mem[a / 4];
        sh = 8 * (a % 4);
        if (sz == 2'd2) return wd;
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic scramble_inputs();
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // One isolated request: checks the accept-cycle RAM drive, the RD_WAIT
    // cycle, response latency and contents.
    task automatic do_req(input bit we, input bit [1:0] sz, input bit uns,
                          input bit [31:0] a, input bit [31:0] wd);
        bit err, slow;
        logic [31:0] exp_rd, exp_wr;
        err    = ref_err(sz, a);
        slow   = !err && !(we && sz == 2'd2);
        exp_rd = (err || we) ? 32'h0 : ref_load(sz, uns, a);
        exp_wr = (we && !err) ? ref_store(sz, a, wd) : 32'h0;

        @(negedge clock);
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        #1;
        chk("acc_ready", req_ready, 1'b1);
        chk("acc_wren", ram_wren, (!err && we && sz == 2'd2));
        if (!err && we && sz == 2'd2) begin
            chk("acc_waddr", ram_address, a[9:2]);
            chk("acc_wdata", ram_data, wd);
        end

        @(negedge clock);
        scramble_inputs();
        #1;
        n_req++;
        if (!slow) begin
            chk("rsp_valid1", rsp_valid, 1'b1);
            chk("rsp_error1", rsp_error, err);
            chk("rsp_rdata1", rsp_rdata, 32'h0);
        end else begin
            chk("wait_valid", rsp_valid, 1'b0);
            chk("wait_ready", req_ready, 1'b0);
            chk("wait_wren", ram_wren, we);
            if (we) begin
                chk("rmw_addr", ram_address, a[9:2]);
                chk("rmw_data", ram_data, exp_wr);
            end
            @(negedge clock);
            #1;
            chk("rsp_valid2", rsp_valid, 1'b1);
            chk("rsp_error2", rsp_error, 1'b0);
            chk("rsp_rdata2", rsp_rdata, exp_rd);
        end
        if (we && !err) ref_mem[a / 4] = exp_wr;
    endtask

    task automatic reset_in_rd_wait();
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h31; req_wdata = 32'h55;
        @(negedge clock);
        scramble_inputs();
        reset = 1'b1;
        #1;
        chk("rst_wren", ram_wren, 1'b0);
        chk("rst_ready_lo", req_ready, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_no_rsp", rsp_valid, 1'b0);
        chk("rst_ready_hi", req_ready, 1'b1);
    endtask

    task automatic back_to_back();
        bit [1:0]    sz  [3];
        bit          we  [3];
        bit          un  [3];
        bit [31:0]   ad  [3];
        bit [31:0]   wd  [3];
        logic [31:0] exp [3];
        int idx = 0;
        int got = 0;
        we[0] = 0; sz[0] = 2'd2; un[0] = 0; ad[0] = 32'h10; wd[0] = 0;
        we[1] = 0; sz[1] = 2'd0; un[1] = 1; ad[1] = 32'h21; wd[1] = 0;
        we[2] = 1; sz[2] = 2'd2; un[2] = 0; ad[2] = 32'h40; wd[2] = $urandom;
        exp[0] = ref_load(sz[0], un[0], ad[0]);
        exp[1] = ref_load(sz[1], un[1], ad[1]);
        exp[2] = 32'h0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clock);
            if (rsp_valid) begin
                chk("b2b_rdata", rsp_rdata, exp[got]);
                chk("b2b_error", rsp_error, 1'b0);
                got++;
            end
            if (idx < 3) begin
                req_valid = 1'b1; req_we = we[idx]; req_size = sz[idx];
                req_unsigned = un[idx]; req_addr = ad[idx]; req_wdata = wd[idx];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (req_valid && req_ready) idx++;
        end
        scramble_inputs();
        n_req += 3;
        chk("b2b_pulses", got, 3);
        chk("b2b_accepts", idx, 3);
        ref_mem[ad[2] / 4] = wd[2];
    endtask

    initial begin
        bit          we, uns;
        bit [1:0]    sz;
        bit [31:0]   a;
        int          r;

        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        reset = 1'b1;
        scramble_inputs();

        @(negedge clock);
        #1;
        chk("reset_ready", req_ready, 1'b0);
        chk("reset_wren", ram_wren, 1'b0);
        @(negedge clock);
        load_ram = 1'b0;
        reset    = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1'b1);
        chk("post_rst_valid", rsp_valid, 1'b0);
        chk("post_rst_error", rsp_error, 1'b0);
        chk("post_rst_rdata", rsp_rdata, 32'h0);

        // Word store then load
        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        do_req(0, 2'd2, 0, 32'h10, 32'h0);
        // Byte merge and extension
        do_req(1, 2'd2, 0, 32'h20, 32'h11223344);
        do_req(1, 2'd0, 0, 32'h21, 32'h000000AA);
        do_req(0, 2'd0, 0, 32'h21, 32'h0);
        do_req(0, 2'd0, 1, 32'h21, 32'h0);
        // Half merge and extension
        do_req(1, 2'd1, 0, 32'h22, 32'h00008001);
        do_req(0, 2'd1, 0, 32'h22, 32'h0);
        do_req(0, 2'd2, 0, 32'h20, 32'h0);
        // Rejected accesses
        do_req(1, 2'd2, 0, 32'h13, 32'hFFFFFFFF);
        do_req(1, 2'd1, 0, 32'h11, 32'hFFFFFFFF);
        do_req(1, 2'd3, 0, 32'h20, 32'hFFFFFFFF);
        do_req(1, 2'd2, 0, 32'h400, 32'hFFFFFFFF);
        do_req(0, 2'd2, 0, 32'h13, 32'h0);
        do_req(0, 2'd2, 0, 32'h20, 32'h0);
        // Reset during a read-modify-write
        do_req(1, 2'd2, 0, 32'h30, 32'hCAFEF00D);
        reset_in_rd_wait();
        do_req(0, 2'd2, 0, 32'h30, 32'h0);
        // Back-to-back with req_valid held high
        back_to_back();
        do_req(0, 2'd2, 0, 32'h40, 32'h0);

        // Randomised traffic over a small window plus occasional wild addresses
        for (int n = 0; n < 300; n++) begin
            r   = int'($urandom % 16);
            sz  = (r == 0) ? 2'd3 : 2'(r % 3);
            we  = 1'($urandom);
            uns = 1'($urandom);
            if ($urandom % 10 == 0) a = $urandom;
            else                    a = $urandom % 64;
            if ($urandom % 4 != 0) begin
                if (sz == 2'd1) a = a & ~32'h1;
                if (sz == 2'd2) a = a & ~32'h3;
            end
            do_req(we, sz, uns, a, $urandom);
        end

        @(negedge clock);
        for (int i = 0; i < NW; i++) chk("mem_final", ram[i], ref_mem[i]);
        chk("pulse_count", n_pulse, n_req);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
